// File: rtl/mem_bus_arbiter.sv
// Shares the single external memory bus between instruction fetch and the MEM stage.
// Data wins ties until fetch has lost STARVE_LIMIT consecutive grants.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic [1:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wrstb,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wrstb,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;

    typedef enum logic [1:0] {StIdle, StFetch, StData, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [31:0]     bus_wdata_q, bus_wdata_d;
    logic [3:0]      bus_wrstb_q, bus_wrstb_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     mem_rdata_q, mem_rdata_d;
    logic            if_done_q, if_done_d;
    logic            mem_done_q, mem_done_d;

    logic store_req, data_req, starve_ok;

    assign store_req = (mem_op == OpStore);
    assign data_req  = (mem_op == OpLoad) || store_req;
    // The counter saturates at the limit, so "below the limit" is just "not at it".
    assign starve_ok = (starve_cnt_q != CntMax);

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wrstb_d  = bus_wrstb_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_done_d    = 1'b0;
        mem_done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (data_req && (!if_req || starve_ok)) begin
                    state_d     = StData;
                    bus_req_d   = 1'b1;
                    bus_we_d    = store_req;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_wrstb_d = store_req ? mem_wrstb : 4'b0000;
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_ok) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d      = StFetch;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = if_addr;
                    bus_wdata_d  = '0;
                    bus_wrstb_d  = 4'b0000;
                    starve_cnt_d = '0;
                end
            end
            StFetch: begin
                if (bus_ack) begin
                    state_d    = StResp;
                    bus_req_d  = 1'b0;
                    if_rdata_d = bus_rdata;
                    if_done_d  = 1'b1;
                end
            end
            StData: begin
                if (bus_ack) begin
                    state_d    = StResp;
                    bus_req_d  = 1'b0;
                    mem_done_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wrstb_q  <= 4'b0000;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_done_q    <= 1'b0;
            mem_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wrstb_q  <= bus_wrstb_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_done_q    <= if_done_d;
            mem_done_q   <= mem_done_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wrstb = bus_wrstb_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = data_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed protocol scenarios plus a randomized run against
// a bus-phase reference model. Inputs change and outputs are sampled at the falling edge.
module tb_mem_bus_arbiter;
    localparam int unsigned Limit = 2;
    localparam logic [1:0] OpNone  = 2'b00;
    localparam logic [1:0] OpLoad  = 2'b01;
    localparam logic [1:0] OpStore = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [1:0]  mem_op = OpNone;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wrstb = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_done, mem_done, stall_if, stall_mem, bus_req, bus_we;
    logic [3:0]  bus_wrstb;

    // Second instance with STARVE_LIMIT=0 and a zero-wait slave that acks immediately.
    logic        if_req0 = 1'b0;
    logic [1:0]  mem_op0 = OpNone;
    logic [31:0] if_rdata0, mem_rdata0, bus_addr0, bus_wdata0, bus_rdata0;
    logic        if_done0, mem_done0, stall_if0, stall_mem0, bus_req0, bus_we0, bus_ack0;
    logic [3:0]  bus_wrstb0;
    assign bus_ack0   = bus_req0;
    assign bus_rdata0 = ~bus_addr0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wrstb(mem_wrstb), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wrstb(bus_wrstb),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    mem_bus_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .if_req(if_req0), .if_addr(if_addr), .if_rdata(if_rdata0),
        .if_done(if_done0), .mem_op(mem_op0), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wrstb(mem_wrstb), .mem_rdata(mem_rdata0), .mem_done(mem_done0),
        .stall_if(stall_if0), .stall_mem(stall_mem0), .bus_req(bus_req0), .bus_we(bus_we0),
        .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_wrstb(bus_wrstb0),
        .bus_ack(bus_ack0), .bus_rdata(bus_rdata0)
    );

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0; if_req = 1'b0; mem_op = OpNone; bus_ack = 1'b0;
        if_req0 = 1'b0; mem_op0 = OpNone;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b0; mem_op = OpNone; bus_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus_req, bus_we, bus_wrstb, if_done, mem_done, stall_if, stall_mem} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {bus_req, bus_we, bus_wrstb, if_done,
                     mem_done, stall_if, stall_mem});
        end
        n_cmp++;
        if ({bus_addr, bus_wdata, if_rdata, mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {bus_addr, bus_wdata, if_rdata, mem_rdata});
        end
        if_req = 1'b1; mem_op = OpStore; #1;
        n_cmp++;
        if ({stall_if, stall_mem, bus_req} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_stall_req: got %b want 110", {stall_if, stall_mem, bus_req});
        end
        if_req = 1'b0; mem_op = OpNone;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100; #1;
        n_cmp++;
        if ({stall_if, bus_req} !== 2'b10) begin
            n_fail++; $display("FAIL fetch_c0: got %b want 10", {stall_if, bus_req});
        end
        @(negedge clk);
        n_cmp++;
        if ({bus_req, bus_we, bus_wrstb, bus_addr} !== {1'b1, 1'b0, 4'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL fetch_c1_bus: got %b/%b/%b/%h want 1/0/0000/100",
                     bus_req, bus_we, bus_wrstb, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF; #1;
        n_cmp++;
        if (stall_if !== 1'b1) begin
            n_fail++; $display("FAIL fetch_c1_stall: got %b want 1", stall_if);
        end
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++;
        if ({bus_req, if_done, stall_if, mem_done} !== 4'b0100 || if_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_c2: got req/done/stall/mdone %b rdata %h want 0100 deadbeef",
                     {bus_req, if_done, stall_if, mem_done}, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus_req, if_done} !== 2'b00) begin
            n_fail++; $display("FAIL fetch_c3: got %b want 00", {bus_req, if_done});
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        mem_op = OpStore; mem_addr = 32'h2000; mem_wdata = 32'h12345678; mem_wrstb = 4'b0011;
        #1;
        n_cmp++;
        if (stall_mem !== 1'b1) begin
            n_fail++; $display("FAIL store_stall: got %b want 1", stall_mem);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_req, bus_we, bus_wrstb, bus_addr, bus_wdata, mem_done} !==
                {1'b1, 1'b1, 4'b0011, 32'h2000, 32'h12345678, 1'b0}) begin
                n_fail++;
                $display("FAIL store_hold c%0d: got %b/%b/%b/%h/%h/%b", c, bus_req, bus_we,
                         bus_wrstb, bus_addr, bus_wdata, mem_done);
            end
            if (c == 4) begin
                bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++;
        if ({bus_req, mem_done, stall_mem} !== 3'b010 || mem_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL store_done: got %b rdata %h want 010 rdata 0",
                     {bus_req, mem_done, stall_mem}, mem_rdata);
        end
        mem_op = OpNone;
        @(negedge clk);
        n_cmp++;
        if (mem_done !== 1'b0) begin
            n_fail++; $display("FAIL store_done_once: got %b want 0", mem_done);
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        mem_op = 2'b11; if_req = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_req, if_done, mem_done, stall_if, stall_mem} !== 5'b0) begin
                n_fail++;
                $display("FAIL spurious: got %b want 00000",
                         {bus_req, if_done, mem_done, stall_if, stall_mem});
            end
        end
        bus_ack = 1'b0; mem_op = OpNone; if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk);
        n_cmp++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h300}) begin
            n_fail++;
            $display("FAIL spurious_then_fetch: got %b/%h want 1/300", bus_req, bus_addr);
        end
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_starve_order();
        int exp_kind [6];
        int got;
        int cyc;
        exp_kind = '{1, 1, 0, 1, 1, 0};
        got = 0;
        cyc = 0;
        pulse_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40; mem_op = OpLoad; mem_addr = 32'h80;
        while (got < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            bus_ack = bus_req;
            if (bus_req) begin
                n_cmp++;
                if (int'(bus_addr == 32'h80) != exp_kind[got]) begin
                    n_fail++;
                    $display("FAIL starve_order grant%0d: got addr %h want %s", got, bus_addr,
                             exp_kind[got] == 1 ? "data" : "fetch");
                end
                got++;
            end
        end
        if (got < 6) begin
            n_cmp++; n_fail++;
            $display("FAIL starve_order_timeout: got %0d grants want 6", got);
        end
        @(negedge clk);
        bus_ack = 1'b0; if_req = 1'b0; mem_op = OpNone;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_limit0();
        logic [31:0] grants [2];
        int got;
        got = 0;
        pulse_reset();
        @(negedge clk);
        if_addr = 32'h44; mem_addr = 32'h88; if_req0 = 1'b1; mem_op0 = OpLoad;
        for (int c = 0; c < 20 && got < 2; c++) begin
            @(negedge clk);
            if (if_done0) if_req0 = 1'b0;
            if (mem_done0) mem_op0 = OpNone;
            if (bus_req0) begin
                grants[got] = bus_addr0;
                got++;
            end
        end
        n_cmp++;
        if (got != 2 || grants[0] !== 32'h44 || grants[1] !== 32'h88) begin
            n_fail++;
            $display("FAIL limit0_order: got %0d grants %h,%h want 44,88", got, grants[0],
                     grants[1]);
        end
        repeat (3) @(negedge clk);
        if_req0 = 1'b0; mem_op0 = OpNone;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        mem_op = OpLoad; mem_addr = 32'h500;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if (bus_req !== 1'b1) begin
                n_fail++; $display("FAIL rif_busy: got %b want 1", bus_req);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_req !== 1'b0) begin
            n_fail++; $display("FAIL rif_async_drop: got %b want 0", bus_req);
        end
        mem_op = OpNone;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_cmp++;
            if ({bus_req, mem_done, if_done} !== 3'b000) begin
                n_fail++; $display("FAIL rif_quiet: got %b want 000", {bus_req, mem_done, if_done});
            end
        end
        if_req = 1'b1; if_addr = 32'h600;
        @(negedge clk);
        n_cmp++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h600}) begin
            n_fail++; $display("FAIL rif_refetch: got %b/%h want 1/600", bus_req, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h600D;
        @(negedge clk);
        bus_ack = 1'b0;
        n_cmp++;
        if (if_done !== 1'b1 || if_rdata !== 32'h600D) begin
            n_fail++;
            $display("FAIL rif_refetch_done: got %b/%h want 1/600d", if_done, if_rdata);
        end
        if_req = 1'b0;
        @(negedge clk);
    endtask

    // Model: the bus is Free, Busy (one transaction outstanding) or Resp (done cycle).
    task automatic test_random();
        int phase, kind, s, wait_left;
        logic armed, f_act, d_act, dp;
        logic [1:0] d_op;
        logic [31:0] f_addr, d_addr, d_wdata, e_addr, e_wdata, e_ird, e_mrd;
        logic [3:0] d_strb, e_strb;
        logic e_we;
        phase = 0; kind = 0; s = 0; wait_left = 0; armed = 1'b0;
        f_act = 1'b0; d_act = 1'b0; d_op = OpNone;
        f_addr = '0; d_addr = '0; d_wdata = '0; d_strb = '0;
        e_addr = '0; e_wdata = '0; e_strb = '0; e_we = 1'b0; e_ird = '0; e_mrd = '0;
        pulse_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (bus_req !== (phase == 1)) begin
                n_fail++; $display("FAIL rnd_bus_req @%0d: got %b want %b", cyc, bus_req, phase == 1);
            end
            if (phase == 1) begin
                n_cmp++;
                if ({bus_we, bus_addr, bus_wrstb} !== {e_we, e_addr, e_strb} ||
                    (e_we && bus_wdata !== e_wdata)) begin
                    n_fail++;
                    $display("FAIL rnd_bus_fields @%0d: got %b/%h/%b/%h want %b/%h/%b/%h", cyc,
                             bus_we, bus_addr, bus_wrstb, bus_wdata, e_we, e_addr, e_strb, e_wdata);
                end
            end
            n_cmp++;
            if ({if_done, mem_done} !== {phase == 2 && kind == 0, phase == 2 && kind != 0}) begin
                n_fail++;
                $display("FAIL rnd_done @%0d: got %b%b want %b%b", cyc, if_done, mem_done,
                         phase == 2 && kind == 0, phase == 2 && kind != 0);
            end
            n_cmp++;
            if (if_rdata !== e_ird || mem_rdata !== e_mrd) begin
                n_fail++;
                $display("FAIL rnd_rdata @%0d: got %h/%h want %h/%h", cyc, if_rdata, mem_rdata,
                         e_ird, e_mrd);
            end
            if (phase == 2 && kind == 0) f_act = 1'b0;
            if (phase == 2 && kind != 0) d_act = 1'b0;
            if (!f_act && $urandom_range(0, 2) == 0) begin
                f_act = 1'b1; f_addr = $urandom;
            end
            if (!d_act && $urandom_range(0, 2) == 0) begin
                d_act = 1'b1; d_op = ($urandom_range(0, 1) == 0) ? OpLoad : OpStore;
                d_addr = $urandom; d_wdata = $urandom; d_strb = 4'($urandom);
            end
            if_req = f_act; if_addr = f_addr;
            mem_op = d_act ? d_op : (($urandom_range(0, 1) == 0) ? OpNone : 2'b11);
            mem_addr = d_addr; mem_wdata = d_wdata; mem_wrstb = d_strb;
            bus_rdata = $urandom;
            if (phase == 1) begin
                if (!armed) begin
                    wait_left = int'($urandom_range(0, 3)); armed = 1'b1;
                end
                bus_ack = (wait_left == 0);
                if (wait_left > 0) wait_left--;
            end else begin
                bus_ack = ($urandom_range(0, 5) == 0);
            end
            #1;
            dp = (mem_op == OpLoad) || (mem_op == OpStore);
            n_cmp++;
            if ({stall_if, stall_mem} !== {if_req && !(phase == 2 && kind == 0),
                                           dp && !(phase == 2 && kind != 0)}) begin
                n_fail++;
                $display("FAIL rnd_stall @%0d: got %b%b", cyc, stall_if, stall_mem);
            end
            if (phase == 1) begin
                if (bus_ack) begin
                    phase = 2; armed = 1'b0;
                    if (kind == 0) e_ird = bus_rdata;
                    else if (kind == 1) e_mrd = bus_rdata;
                end
            end else if (phase == 2) begin
                phase = 0;
            end else if (dp && (!if_req || s < int'(Limit))) begin
                phase = 1; kind = (mem_op == OpLoad) ? 1 : 2;
                e_we = (kind == 2); e_addr = mem_addr; e_wdata = mem_wdata;
                e_strb = e_we ? mem_wrstb : 4'b0000;
                s = if_req ? ((s < int'(Limit)) ? s + 1 : s) : 0;
            end else if (if_req) begin
                phase = 1; kind = 0; e_we = 1'b0; e_addr = if_addr; e_strb = 4'b0000; s = 0;
            end
        end
        pulse_reset();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_spurious();
        test_starve_order();
        test_limit0();
        test_reset_in_flight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d failed %0d",
                 n_cmp, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences the single external memory bus between the instruction-fetch stage and the MEM stage of the five-stage core. Grants one request at a time, drives a registered bus transaction with a req/ack handshake and returns read data. Generates per-stage stall signals. Data accesses have priority, bounded by a starvation counter that guarantees forward progress for fetch.

## Interface
Parameters:
- STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending; 0 = fetch always wins a tie

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch address (u32_t)
- if_rdata  out  32  fetched word, valid when if_done
- if_done  out  1  one-cycle fetch completion pulse
- mem_op  in  2  mem_op_t; LOAD/STORE = request, held until mem_done; NONE and 2'b11 = no request
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_wrstb  in  4  store byte strobes (wrstb_t)
- mem_rdata  out  32  load data, valid when mem_done
- mem_done  out  1  one-cycle data completion pulse
- stall_if  out  1  if_req & ~if_done (combinational)
- stall_mem  out  1  data request & ~mem_done (combinational)
- bus_req  out  1  bus transaction active (registered)
- bus_we  out  1  1 = write
- bus_addr  out  32  bus address
- bus_wdata  out  32  write data
- bus_wrstb  out  4  byte strobes; 4'b0000 on reads and fetches
- bus_ack  in  1  slave completion, sampled while bus_req high
- bus_rdata  in  32  read data, valid with bus_ack

## Operation
- States: IDLE, FETCH, DATA, RESP.
- IDLE grant decision (one per cycle, only in IDLE):
  - data pending and (~if_req or starve_cnt < STARVE_LIMIT) -> DATA
  - else if_req -> FETCH
  - else stay IDLE
- On grant: register bus_addr/bus_we/bus_wdata/bus_wrstb from the granted requester; set bus_req. Fetch: bus_we=0, wrstb=0. Load: bus_we=0, wrstb=0. Store: bus_we=1, wrstb=mem_wrstb.
- FETCH/DATA: bus outputs held stable until bus_ack. On bus_ack: bus_req cleared, bus_rdata captured into if_rdata (FETCH) or mem_rdata (LOAD), go to RESP.
- Stores leave mem_rdata unchanged.
- RESP: corresponding done high for exactly this cycle; no grant made (requester still holds its request this cycle); -> IDLE.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - DATA grant with if_req high: +1, saturating
  - FETCH grant, or DATA grant with if_req low: cleared
- Requester inputs are not sampled after grant; changes during FETCH/DATA are ignored.

## Timing
- Reset (async, any state): state=IDLE, starve_cnt=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wrstb=0, if_rdata=0, mem_rdata=0, if_done=0, mem_done=0. Transaction in flight is abandoned; bus_req drops immediately.
- Latency with request in IDLE at cycle 0: bus_req high cycle 1; ack in cycle 1+W (W wait states); done in cycle 2+W. Minimum 3 cycles request-to-next-grant.
- bus_ack while bus_req low: ignored.
- Simultaneous fetch and data in IDLE: resolved by the grant rule; loser stalls and is re-evaluated at next IDLE.
- Data request and fetch arriving in RESP: not granted until following IDLE cycle.
- stall_* are combinational from inputs and done registers; both low during reset unless requests asserted.

## Test plan
- Single fetch, if_addr=0x100, bus_ack in cycle 1, bus_rdata=0xDEADBEEF -> bus_req cycle 1 only, if_done cycle 2 with if_rdata=0xDEADBEEF, stall_if high cycles 0–1.
- Store mem_addr=0x2000, mem_wdata=0x12345678, wrstb=4'b0011, ack after 3 wait states -> bus_we=1, strobes 0011 held 4 cycles, mem_done once, mem_rdata unchanged.
- Fetch and load both held continuously, STARVE_LIMIT=2, loads re-issued after each done -> grant order DATA, DATA, FETCH, repeating.
- STARVE_LIMIT=0, fetch and load pending together -> FETCH granted first, then DATA.
- rst_n asserted in DATA with bus_req high -> bus_req 0 immediately, no done pulse, after release new fetch completes normally.
- Spurious bus_ack in IDLE and mem_op=2'b11 -> no state change, no bus_req, no done.
